pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the pipelined RISC-V datapath, replacing bare clear-able flops between stages. Adds a valid/ready handshake, a synchronous flush, bubble injection, and an optional 2-entry skid mode. Skid mode gives full throughput with a registered in_ready, so stall paths are not combinational across stages. Includes a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers and perf counters.
// Pure types and constants, no logic.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // addi x0,x0,0: bubble encoding for instruction-carrying stages
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; counts cycles with inc high and sticks at all-ones.
// Latency: count reflects inc one cycle later. No backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready, flush, bubble output and optional 2-entry skid.
// Latency 1 cycle; SKID=1 registers in_ready, SKID=0 derives it combinationally from out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] main_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             stall_inc;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign stall_inc = out_valid & ~out_ready;
  assign out_data  = out_valid ? main_q : NOP_VALUE;

  generate
    if (SKID != 0) begin : g_skid
      stage_state_t     state_q;
      stage_state_t     state_d;
      logic [WIDTH-1:0] skid_q;
      logic             ready_q;

      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_EMPTY: if (in_xfer) state_d = ST_ONE;
          ST_ONE: begin
            if (in_xfer && !out_xfer)      state_d = ST_TWO;
            else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
          end
          ST_TWO:   if (out_xfer) state_d = ST_ONE;
          default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
      end

      // in_ready is precomputed from the next state so no stall path crosses the stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          ready_q <= (state_d != ST_TWO);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          if ((state_q == ST_EMPTY && in_xfer) ||
              (state_q == ST_ONE && in_xfer && out_xfer)) begin
            main_q <= in_data;
          end else if (state_q == ST_TWO && out_xfer) begin
            main_q <= skid_q;
          end
          if (state_q == ST_ONE && in_xfer && !out_xfer) begin
            skid_q <= in_data;
          end
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = (state_q != ST_EMPTY);
      assign occupancy = state_q;
    end else begin : g_pass
      logic valid_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_xfer) begin
          valid_q <= 1'b1;
          main_q  <= in_data;
        end else if (out_xfer) begin
          valid_q <= 1'b0;
        end
      end

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two SKID=1 instances (16- and 4-bit counters) share one stimulus,
// a SKID=0 instance has its own; all are compared against queue-based models.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam logic [31:0] NOP_S = NOP_INSN;
  localparam logic [31:0] NOP_P = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  logic        c_flush = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [31:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [1:0]  c_occ;
  logic [15:0] c_stall;

  pipe_stage_skid #(.WIDTH(32), .SKID(1), .NOP_VALUE(NOP_S), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_skid #(.WIDTH(32), .SKID(1), .NOP_VALUE(NOP_S), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(b_in_ready),
    .in_data(a_in_data), .out_valid(b_out_valid), .out_ready(a_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall));

  pipe_stage_skid #(.WIDTH(32), .SKID(0), .NOP_VALUE(NOP_P), .CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_cnt(c_stall));

  // Reference model: FIFO contents of each stage plus raw stall-cycle counts
  logic [31:0] q_s[$];
  logic [31:0] q_p[$];
  int ns = 0, np = 0;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [35:0] exp_s();
    logic [31:0] d;
    d = (q_s.size() != 0) ? q_s[0] : NOP_S;
    return {2'(q_s.size()), (q_s.size() < 2), (q_s.size() != 0), d};
  endfunction

  function automatic logic [35:0] exp_p();
    logic [31:0] d;
    d = (q_p.size() != 0) ? q_p[0] : NOP_P;
    return {2'(q_p.size()), ((q_p.size() == 0) || c_out_ready), (q_p.size() != 0), d};
  endfunction

  function automatic logic [15:0] sat16(int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [3:0] sat4(int n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  // One clock: transfers decided from model state and current inputs, applied after the edge
  task automatic tick();
    bit s_in, s_out, s_st, s_fl, p_in, p_out, p_st, p_fl;
    logic [31:0] sd, pd;
    s_in  = a_in_valid && (q_s.size() < 2);
    s_out = (q_s.size() != 0) && a_out_ready;
    s_st  = (q_s.size() != 0) && !a_out_ready;
    s_fl  = a_flush;
    sd    = a_in_data;
    p_in  = c_in_valid && ((q_p.size() == 0) || c_out_ready);
    p_out = (q_p.size() != 0) && c_out_ready;
    p_st  = (q_p.size() != 0) && !c_out_ready;
    p_fl  = c_flush;
    pd    = c_in_data;
    @(posedge clk);
    #1;
    if (s_st) ns++;
    if (p_st) np++;
    if (s_fl) q_s.delete();
    else begin
      if (s_out) void'(q_s.pop_front());
      if (s_in) q_s.push_back(sd);
    end
    if (p_fl) q_p.delete();
    else begin
      if (p_out) void'(q_p.pop_front());
      if (p_in) q_p.push_back(pd);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data} !== {2'd0, 1'b1, 1'b0, NOP_S}) begin
      n_bad++;
      $display("FAIL reset_a_state: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_data}, {2'd0, 1'b1, 1'b0, NOP_S});
    end
    n_cmp++;
    if ({c_occ, c_in_ready, c_out_valid, c_out_data} !== {2'd0, 1'b1, 1'b0, NOP_P}) begin
      n_bad++;
      $display("FAIL reset_c_state: got %h want %h", {c_occ, c_in_ready, c_out_valid, c_out_data}, {2'd0, 1'b1, 1'b0, NOP_P});
    end
    n_cmp++;
    if (a_stall !== 16'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i);
      #1;
      n_cmp++;
      if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); end
      tick();
      n_cmp++;
      if ({a_out_valid, a_out_data} !== {1'b1, 32'(i)}) begin
        n_bad++;
        $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 32'(i));
      end
    end
    a_in_valid = 1'b0;
    n_cmp++;
    if (a_stall !== 16'd0) begin n_bad++; $display("FAIL stream_stall: got %0d want 0", a_stall); end
    tick();
    n_cmp++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data} !== exp_s()) begin
      n_bad++;
      $display("FAIL stream_drain: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_data}, exp_s());
    end
  endtask

  task automatic test_backpressure();
    int st0;
    st0 = ns;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    tick();
    n_cmp++;
    if ({a_occ, a_out_data} !== {2'd1, 32'hA}) begin n_bad++; $display("FAIL bp_fill1: got occ=%0d d=%h want occ=1 d=a", a_occ, a_out_data); end
    a_in_data = 32'hB;
    tick();
    n_cmp++;
    if ({a_occ, a_in_ready, a_out_data} !== {2'd2, 1'b0, 32'hA}) begin
      n_bad++;
      $display("FAIL bp_fill2: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a", a_occ, a_in_ready, a_out_data);
    end
    a_in_data = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({a_occ, a_in_ready, a_out_valid, a_out_data} !== {2'd2, 1'b0, 1'b1, 32'hA}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got %h want %h", k, {a_occ, a_in_ready, a_out_valid, a_out_data}, {2'd2, 1'b0, 1'b1, 32'hA});
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({a_occ, a_in_ready, a_out_data} !== {2'd1, 1'b1, 32'hB}) begin
      n_bad++;
      $display("FAIL bp_drain1: got occ=%0d rdy=%b d=%h want occ=1 rdy=1 d=b", a_occ, a_in_ready, a_out_data);
    end
    tick();
    n_cmp++;
    if ({a_occ, a_out_valid, a_out_data} !== {2'd0, 1'b0, NOP_S}) begin
      n_bad++;
      $display("FAIL bp_drain2: got occ=%0d v=%b d=%h want empty nop", a_occ, a_out_valid, a_out_data);
    end
    n_cmp++;
    if (a_stall !== sat16(st0 + 4)) begin n_bad++; $display("FAIL bp_stall: got %0d want %0d", a_stall, st0 + 4); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h1;
    tick();
    a_in_data = 32'h2;
    tick();
    a_flush   = 1'b1;
    a_in_data = 32'hC;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    n_cmp++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data} !== {2'd0, 1'b1, 1'b0, NOP_S}) begin
      n_bad++;
      $display("FAIL flush_clear: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_data}, {2'd0, 1'b1, 1'b0, NOP_S});
    end
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({a_out_valid, a_out_data} !== {1'b0, NOP_S}) begin
        n_bad++;
        $display("FAIL flush_no_leak[%0d]: got v=%b d=%h want v=0 d=%h", k, a_out_valid, a_out_data, NOP_S);
      end
    end
    n_cmp++;
    if (a_stall !== sat16(ns)) begin n_bad++; $display("FAIL flush_stall_kept: got %0d want %0d", a_stall, ns); end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h77;
    tick();
    a_in_data = 32'h78;
    tick();
    a_in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_occ, a_out_valid, a_out_data} !== {2'd0, 1'b0, NOP_S}) begin
      n_bad++;
      $display("FAIL rst_mid_async: got occ=%0d v=%b d=%h want 0 0 %h", a_occ, a_out_valid, a_out_data, NOP_S);
    end
    n_cmp++;
    if ({a_stall, b_stall} !== 20'd0) begin n_bad++; $display("FAIL rst_mid_stall: got %0d/%0d want 0/0", a_stall, b_stall); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    q_s.delete();
    q_p.delete();
    ns = 0;
    np = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data} !== {2'd0, 1'b1, 1'b0, NOP_S}) begin
      n_bad++;
      $display("FAIL rst_mid_release: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_data}, {2'd0, 1'b1, 1'b0, NOP_S});
    end
  endtask

  task automatic test_pass();
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_data   = 32'h11;
    #1;
    n_cmp++;
    if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL pass_empty_ready: got %b want 1", c_in_ready); end
    tick();
    c_in_data = 32'h22;
    #1;
    n_cmp++;
    if ({c_out_valid, c_out_data, c_in_ready} !== {1'b1, 32'h11, 1'b0}) begin
      n_bad++;
      $display("FAIL pass_stall_ready: got v=%b d=%h rdy=%b want 1 11 0", c_out_valid, c_out_data, c_in_ready);
    end
    tick();
    n_cmp++;
    if (c_out_data !== 32'h11) begin n_bad++; $display("FAIL pass_hold: got %h want 11", c_out_data); end
    c_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL pass_comb_ready: got %b want 1", c_in_ready); end
    tick();
    n_cmp++;
    if ({c_out_valid, c_out_data} !== {1'b1, 32'h22}) begin
      n_bad++;
      $display("FAIL pass_replace: got v=%b d=%h want 1 22", c_out_valid, c_out_data);
    end
    c_in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({c_occ, c_out_valid, c_out_data, c_stall} !== {2'd0, 1'b0, NOP_P, sat16(np)}) begin
      n_bad++;
      $display("FAIL pass_empty: got occ=%0d v=%b d=%h st=%0d want 0 0 %h %0d", c_occ, c_out_valid, c_out_data, c_stall, NOP_P, np);
    end
    c_out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h5A;
    tick();
    a_in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if ({b_stall, a_stall} !== {sat4(ns), sat16(ns)}) begin
        n_bad++;
        $display("FAIL sat_cnt[%0d]: got b=%0d a=%0d want b=%0d a=%0d", k, b_stall, a_stall, sat4(ns), sat16(ns));
      end
    end
    n_cmp++;
    if (b_stall !== 4'hF) begin n_bad++; $display("FAIL sat_final: got %0d want 15", b_stall); end
    a_out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 19) == 0);
      c_in_valid  = 1'($urandom_range(0, 1));
      c_in_data   = $urandom;
      c_out_ready = ($urandom_range(0, 2) != 0);
      c_flush     = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++;
      if ({a_occ, a_in_ready, a_out_valid, a_out_data, a_stall} !== {exp_s(), sat16(ns)}) begin
        n_bad++;
        $display("FAIL rand_a[%0d]: got %h/%0d want %h/%0d", k, {a_occ, a_in_ready, a_out_valid, a_out_data}, a_stall, exp_s(), ns);
      end
      n_cmp++;
      if ({b_occ, b_in_ready, b_out_valid, b_out_data, b_stall} !== {exp_s(), sat4(ns)}) begin
        n_bad++;
        $display("FAIL rand_b[%0d]: got %h/%0d want %h/%0d", k, {b_occ, b_in_ready, b_out_valid, b_out_data}, b_stall, exp_s(), sat4(ns));
      end
      n_cmp++;
      if ({c_occ, c_in_ready, c_out_valid, c_out_data, c_stall} !== {exp_p(), sat16(np)}) begin
        n_bad++;
        $display("FAIL rand_c[%0d]: got %h/%0d want %h/%0d", k, {c_occ, c_in_ready, c_out_valid, c_out_data}, c_stall, exp_p(), np);
      end
      tick();
    end
    a_flush = 1'b0;
    c_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_pass();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
